pkt_fifo: RTL and testbench
===========================

Name: pkt_fifo

Overview:
Parametrised store-and-forward packet FIFO, the successor to the single-clock word FIFO. The write side accepts framed packets with end-of-packet and error markers. Only complete, error-free packets become visible on a valid/ready showahead read port. Packets that are errored or overflow the buffer are discarded by rewinding the write pointer. It sits between packet producers (parsers, MAC RX) and consumers that need whole packets.

Parameters:
DWIDTH, 8, data word width
AWIDTH, 4, address width; depth = 2**AWIDTH words
ALMOST_FULL_VALUE, 12, almost_full_o threshold (usedw >= value)
ALMOST_EMPTY_VALUE, 4, almost_empty_o threshold (usedw < value)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
data_i  in  DWIDTH  write data
wrreq_i  in  1  write request, one word per cycle
eop_i  in  1  last word of packet, qualified by wrreq_i
err_i  in  1  packet error, sampled with eop word; 1 = discard packet
rd_ready_i  in  1  consumer ready
rd_valid_o  out  1  q_o/q_eop_o hold a committed word
q_o  out  DWIDTH  read data, showahead
q_eop_o  out  1  q_o is last word of its packet
usedw_o  out  AWIDTH+1  stored words, committed unread plus uncommitted
full_o  out  1  usedw_o == 2**AWIDTH
empty_o  out  1  no committed unread words
almost_full_o  out  1  usedw_o >= ALMOST_FULL_VALUE
almost_empty_o  out  1  usedw_o < ALMOST_EMPTY_VALUE
pkt_cnt_o  out  AWIDTH+1  committed packets not yet fully read
drop_o  out  1  one-cycle pulse: a packet was discarded

Behaviour:
- Reset (rst_n_i low, asynchronous): all pointers and counters are 0. rd_valid_o=0, q_eop_o=0, usedw_o=0, full_o=0, empty_o=1, almost_full_o=0, almost_empty_o=(ALMOST_EMPTY_VALUE>0), pkt_cnt_o=0, drop_o=0. q_o is don't-care. A packet in progress at reset is lost without a drop_o pulse.
- Pointers: rd_ptr, commit_ptr and wr_ptr, each AWIDTH+1 bits with a wrap bit; wrap-around is natural modulo 2**AWIDTH.
- Memory stores {eop, data}, DWIDTH+1 bits. Synchronous-read RAM feeds a prefetch output register.
- Write: word accepted when wrreq_i=1, full_o=0 and no drop is pending; stored at wr_ptr, wr_ptr++.
- Commit: the eop word is accepted with err_i=0 at edge N. At edge N, commit_ptr <= wr_ptr+1 and pkt_cnt_o increments.
- Discard condition 1: eop word arrives with err_i=1. The eop word is not stored and wr_ptr <= commit_ptr.
- Discard condition 2: wrreq_i=1 while full_o=1. The word is rejected, wr_ptr <= commit_ptr and a drop-pending flag is set. Further words are ignored up to and including the next eop. There is no read/write-when-full exception.
- drop_o: pulses the cycle after the discarding eop is presented, exactly once per discarded packet.
- usedw_o: falls by the number of uncommitted words on a rewind. A packet longer than 2**AWIDTH is always discarded.
- Read transfer occurs when rd_valid_o & rd_ready_i. The next word is presented the following cycle with no bubble while committed data remain, sustaining 1 word/cycle.
- Read latency: a commit at edge N gives rd_valid_o=1 with the packet's first word after edge N+1, provided the FIFO was previously drained.
- A read of a word with eop=1 decrements pkt_cnt_o.
- rd_valid_o, q_o and q_eop_o are stable while rd_valid_o=1 and rd_ready_i=0.
- Uncommitted words are never visible on the read side. Reading never overtakes commit_ptr.
- Simultaneous events:
  - Accepted write and read in the same cycle: usedw_o unchanged.
  - Commit and eop read in the same cycle: pkt_cnt_o unchanged.
  - A read in the same cycle as a rewind is still honoured.
- empty_o = (rd_ptr == commit_ptr), excluding the prefetched word. full_o, almost flags and empty_o are registered and consistent with usedw_o in the same cycle.

Test Plan:
- Reset, then 3-word packet {0x11,0x22,0x33(eop)} with rd_ready_i=0 -> after the eop edge, usedw_o=3 and pkt_cnt_o=1; next cycle rd_valid_o=1, q_o=0x11. Then rd_ready_i=1 -> q_o 0x22, then 0x33 with q_eop_o=1; afterwards empty_o=1 and pkt_cnt_o=0.
- 4-word packet with err_i=1 on eop -> rd_valid_o stays 0, drop_o pulses once, usedw_o returns to 0.
- Commit a 10-word packet, then start a 7-word packet, no reads -> 6 words stored; on the 7th word full_o=1, usedw_o=16 and the word is rejected; usedw_o becomes 10 and drop_o pulses after that packet's eop. Then read -> exactly the original 10 words.
- 20-word packet into empty FIFO -> discarded, drop_o=1 once, FIFO empty. A following 2-word packet is delivered intact.
- Continuous 1-word packets written and read every cycle for 3*2**AWIDTH cycles -> pointer wrap, in-order data, usedw_o bounded at 2, no drop_o.
- rst_n_i pulsed low mid-packet between edges -> outputs reach reset values immediately, not at the next edge; a subsequent packet is delivered correctly.

Source files
------------

// File: rtl/pkt_fifo.sv
// Store-and-forward packet FIFO: only complete, error-free packets reach the
// read port; errored or oversized packets are rewound away on the write side.
module pkt_fifo #(
    parameter int DWIDTH             = 8,
    parameter int AWIDTH             = 4,
    parameter int ALMOST_FULL_VALUE  = 12,
    parameter int ALMOST_EMPTY_VALUE = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              eop_i,
    input  logic              err_i,
    input  logic              rd_ready_i,
    output logic              rd_valid_o,
    output logic [DWIDTH-1:0] q_o,
    output logic              q_eop_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [AWIDTH:0]   pkt_cnt_o,
    output logic              drop_o
);

    localparam int DEPTH = 2 ** AWIDTH;

    typedef logic [AWIDTH:0] ptr_t;

    typedef enum logic [0:0] {
        S_PASS,
        S_SKIP
    } wstate_t;

    localparam ptr_t ONE      = ptr_t'(1);
    localparam ptr_t FULL_LVL = ptr_t'(DEPTH);
    localparam ptr_t AF_LVL   = ptr_t'(ALMOST_FULL_VALUE);
    localparam ptr_t AE_LVL   = ptr_t'(ALMOST_EMPTY_VALUE);
    localparam logic AE_RST   = (ALMOST_EMPTY_VALUE > 0);

    logic [DWIDTH:0] mem [DEPTH];

    ptr_t wr_ptr;
    ptr_t commit_ptr;
    ptr_t rd_ptr;
    ptr_t wr_nxt;
    ptr_t commit_nxt;
    ptr_t rd_nxt;
    ptr_t tail_nxt;
    ptr_t usedw_nxt;
    ptr_t pkt_nxt;

    wstate_t state;
    wstate_t state_nxt;

    logic store;
    logic commit;
    logic rewind;
    logic drop_now;
    logic xfer;
    logic eop_out;
    logic load;
    logic valid_nxt;

    logic              rd_valid;
    logic [DWIDTH-1:0] q;
    logic              q_eop;
    ptr_t              usedw;
    logic              full;
    logic              empty;
    logic              afull;
    logic              aempty;
    ptr_t              pkt_cnt;
    logic              drop;

    // Write-side packet framing: S_SKIP swallows the tail of a packet
    // that already hit a full buffer, up to and including its eop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_PASS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        store     = 1'b0;
        commit    = 1'b0;
        rewind    = 1'b0;
        drop_now  = 1'b0;
        unique case (state)
            S_PASS: begin
                if (wrreq_i) begin
                    if (full) begin
                        rewind = 1'b1;
                        if (eop_i) begin
                            drop_now = 1'b1;
                        end else begin
                            state_nxt = S_SKIP;
                        end
                    end else if (eop_i && err_i) begin
                        rewind   = 1'b1;
                        drop_now = 1'b1;
                    end else begin
                        store  = 1'b1;
                        commit = eop_i;
                    end
                end
            end
            S_SKIP: begin
                if (wrreq_i && eop_i) begin
                    drop_now  = 1'b1;
                    state_nxt = S_PASS;
                end
            end
            default: state_nxt = S_PASS;
        endcase
    end

    always_comb begin
        wr_nxt = wr_ptr;
        if (rewind) begin
            wr_nxt = commit_ptr;
        end else if (store) begin
            wr_nxt = wr_ptr + ONE;
        end
    end

    assign commit_nxt = commit ? wr_ptr + ONE : commit_ptr;

    // Read side: the RAM output register doubles as the showahead register.
    assign xfer      = rd_valid & rd_ready_i;
    assign eop_out   = xfer & q_eop;
    assign load      = (rd_ptr != commit_ptr) && (!rd_valid || rd_ready_i);
    assign rd_nxt    = load ? rd_ptr + ONE : rd_ptr;
    assign valid_nxt = load | (rd_valid & ~rd_ready_i);

    // Oldest word not yet handed to the consumer, including the prefetched one.
    assign tail_nxt  = rd_nxt - ptr_t'(valid_nxt);
    assign usedw_nxt = wr_nxt - tail_nxt;

    always_comb begin
        pkt_nxt = pkt_cnt;
        unique case ({commit, eop_out})
            2'b10:   pkt_nxt = pkt_cnt + ONE;
            2'b01:   pkt_nxt = pkt_cnt - ONE;
            default: pkt_nxt = pkt_cnt;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (store) begin
            mem[wr_ptr[AWIDTH-1:0]] <= {eop_i, data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            rd_valid   <= 1'b0;
            q          <= '0;
            q_eop      <= 1'b0;
            usedw      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            afull      <= 1'b0;
            aempty     <= AE_RST;
            pkt_cnt    <= '0;
            drop       <= 1'b0;
        end else begin
            wr_ptr     <= wr_nxt;
            commit_ptr <= commit_nxt;
            rd_ptr     <= rd_nxt;
            rd_valid   <= valid_nxt;
            if (load) begin
                {q_eop, q} <= mem[rd_ptr[AWIDTH-1:0]];
            end
            usedw      <= usedw_nxt;
            full       <= (usedw_nxt == FULL_LVL);
            empty      <= (rd_nxt == commit_nxt);
            afull      <= (usedw_nxt >= AF_LVL);
            aempty     <= (usedw_nxt < AE_LVL);
            pkt_cnt    <= pkt_nxt;
            drop       <= drop_now;
        end
    end

    assign rd_valid_o     = rd_valid;
    assign q_o            = q;
    assign q_eop_o        = q_eop;
    assign usedw_o        = usedw;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = afull;
    assign almost_empty_o = aempty;
    assign pkt_cnt_o      = pkt_cnt;
    assign drop_o         = drop;

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed bench for pkt_fifo: framing, discard, overflow, wrap and
// asynchronous reset, all against hand-computed expectations.
module tb_pkt_fifo;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          wrreq;
    logic          eop;
    logic          err;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] q;
    logic          q_eop;
    logic [AW:0]   usedw;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;
    logic [AW:0]   pkt_cnt;
    logic          drop;

    int checks = 0;
    int errors = 0;
    int drops  = 0;
    int d0;
    int got;
    int mx;

    pkt_fifo #(
        .DWIDTH(DW),
        .AWIDTH(AW),
        .ALMOST_FULL_VALUE(12),
        .ALMOST_EMPTY_VALUE(4)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .data_i(data),
        .wrreq_i(wrreq),
        .eop_i(eop),
        .err_i(err),
        .rd_ready_i(rd_ready),
        .rd_valid_o(rd_valid),
        .q_o(q),
        .q_eop_o(q_eop),
        .usedw_o(usedw),
        .full_o(full),
        .empty_o(empty),
        .almost_full_o(afull),
        .almost_empty_o(aempty),
        .pkt_cnt_o(pkt_cnt),
        .drop_o(drop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (drop) drops++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d, input logic e, input logic r);
        wrreq = 1'b1;
        data  = d;
        eop   = e;
        err   = r;
        cyc();
        wrreq = 1'b0;
        eop   = 1'b0;
        err   = 1'b0;
    endtask

    task automatic read_seq(input string tag, input int start,
                            input int step, input int len);
        int n = 0;
        rd_ready = 1'b1;
        for (int c = 0; c < len + 8 && n < len; c++) begin
            if (rd_valid) begin
                chk(tag, 32'(q), 32'((start + n * step) & 'hff));
                chk({tag, " eop"}, 32'(q_eop), 32'(n == len - 1));
                n++;
            end
            cyc();
        end
        rd_ready = 1'b0;
        chk({tag, " count"}, 32'(n), 32'(len));
    endtask

    initial begin
        rst_n    = 1'b0;
        data     = '0;
        wrreq    = 1'b0;
        eop      = 1'b0;
        err      = 1'b0;
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst rd_valid", 32'(rd_valid), 0);
        chk("rst q_eop", 32'(q_eop), 0);
        chk("rst usedw", 32'(usedw), 0);
        chk("rst full", 32'(full), 0);
        chk("rst empty", 32'(empty), 1);
        chk("rst afull", 32'(afull), 0);
        chk("rst aempty", 32'(aempty), 1);
        chk("rst pkt_cnt", 32'(pkt_cnt), 0);
        chk("rst drop", 32'(drop), 0);
        rst_n = 1'b1;
        cyc();

        // 3-word packet, held then drained
        put(8'h11, 1'b0, 1'b0);
        put(8'h22, 1'b0, 1'b0);
        put(8'h33, 1'b1, 1'b0);
        chk("p3 usedw", 32'(usedw), 3);
        chk("p3 pkt_cnt", 32'(pkt_cnt), 1);
        chk("p3 latency", 32'(rd_valid), 0);
        chk("p3 aempty", 32'(aempty), 1);
        cyc();
        chk("p3 valid", 32'(rd_valid), 1);
        chk("p3 q0", 32'(q), 'h11);
        chk("p3 q0 eop", 32'(q_eop), 0);
        chk("p3 not empty", 32'(empty), 0);
        cyc();
        chk("p3 hold valid", 32'(rd_valid), 1);
        chk("p3 hold q", 32'(q), 'h11);
        rd_ready = 1'b1;
        cyc();
        chk("p3 q1", 32'(q), 'h22);
        cyc();
        chk("p3 q2", 32'(q), 'h33);
        chk("p3 q2 eop", 32'(q_eop), 1);
        chk("p3 empty", 32'(empty), 1);
        cyc();
        chk("p3 drained", 32'(rd_valid), 0);
        chk("p3 pkt_cnt 0", 32'(pkt_cnt), 0);
        chk("p3 usedw 0", 32'(usedw), 0);
        rd_ready = 1'b0;

        // errored packet
        d0 = drops;
        put(8'hA0, 1'b0, 1'b0);
        put(8'hA1, 1'b0, 1'b0);
        put(8'hA2, 1'b0, 1'b0);
        chk("err usedw 3", 32'(usedw), 3);
        put(8'hA3, 1'b1, 1'b1);
        chk("err drop", 32'(drop), 1);
        chk("err usedw", 32'(usedw), 0);
        chk("err valid", 32'(rd_valid), 0);
        cyc();
        chk("err drop end", 32'(drop), 0);
        chk("err drop once", 32'(drops - d0), 1);
        chk("err empty", 32'(empty), 1);
        chk("err valid2", 32'(rd_valid), 0);

        // overflow on second packet
        for (int i = 0; i < 10; i++) put(8'(8'h40 + i), 1'(i == 9), 1'b0);
        chk("p10 pkt_cnt", 32'(pkt_cnt), 1);
        chk("p10 usedw", 32'(usedw), 10);
        chk("p10 aempty", 32'(aempty), 0);
        chk("p10 afull", 32'(afull), 0);
        d0 = drops;
        for (int i = 0; i < 6; i++) put(8'(8'h80 + i), 1'b0, 1'b0);
        chk("ovf usedw 16", 32'(usedw), 16);
        chk("ovf full", 32'(full), 1);
        chk("ovf afull", 32'(afull), 1);
        chk("ovf no drop yet", 32'(drop), 0);
        put(8'h86, 1'b1, 1'b0);
        chk("ovf usedw 10", 32'(usedw), 10);
        chk("ovf full clr", 32'(full), 0);
        chk("ovf drop", 32'(drop), 1);
        chk("ovf pkt_cnt", 32'(pkt_cnt), 1);
        cyc();
        chk("ovf drop once", 32'(drops - d0), 1);
        read_seq("p10 data", 'h40, 1, 10);
        cyc();
        chk("p10 empty", 32'(empty), 1);
        chk("p10 usedw 0", 32'(usedw), 0);
        chk("p10 pkt_cnt 0", 32'(pkt_cnt), 0);
        chk("p10 valid", 32'(rd_valid), 0);

        // oversized packet into empty FIFO
        d0 = drops;
        for (int i = 0; i < 20; i++) put(8'(8'h60 + i), 1'(i == 19), 1'b0);
        cyc();
        chk("big drop once", 32'(drops - d0), 1);
        chk("big usedw", 32'(usedw), 0);
        chk("big empty", 32'(empty), 1);
        chk("big valid", 32'(rd_valid), 0);
        chk("big pkt_cnt", 32'(pkt_cnt), 0);
        put(8'hC1, 1'b0, 1'b0);
        put(8'hC2, 1'b1, 1'b0);
        read_seq("p2 data", 'hC1, 1, 2);

        // streaming 1-word packets through pointer wrap
        d0 = drops;
        got = 0;
        mx = 0;
        rd_ready = 1'b1;
        for (int i = 0; i < 52; i++) begin
            if (i < 48) begin
                wrreq = 1'b1;
                data  = 8'(i);
                eop   = 1'b1;
            end else begin
                wrreq = 1'b0;
                eop   = 1'b0;
            end
            cyc();
            if (int'(usedw) > mx) mx = int'(usedw);
            if (rd_valid) begin
                chk("wrap data", 32'(q), 32'(got & 'hff));
                got++;
            end
        end
        rd_ready = 1'b0;
        chk("wrap count", 32'(got), 48);
        chk("wrap usedw max", 32'(mx), 2);
        chk("wrap no drop", 32'(drops - d0), 0);
        chk("wrap pkt_cnt", 32'(pkt_cnt), 0);

        // asynchronous reset mid-packet
        put(8'h55, 1'b1, 1'b0);
        cyc();
        chk("ar prefetch", 32'(rd_valid), 1);
        put(8'h70, 1'b0, 1'b0);
        put(8'h71, 1'b0, 1'b0);
        d0 = drops;
        #2 rst_n = 1'b0;
        #1;
        chk("ar valid", 32'(rd_valid), 0);
        chk("ar q_eop", 32'(q_eop), 0);
        chk("ar usedw", 32'(usedw), 0);
        chk("ar pkt_cnt", 32'(pkt_cnt), 0);
        chk("ar empty", 32'(empty), 1);
        chk("ar aempty", 32'(aempty), 1);
        #2 rst_n = 1'b1;
        cyc();
        put(8'hE1, 1'b0, 1'b0);
        put(8'hE2, 1'b0, 1'b0);
        put(8'hE3, 1'b1, 1'b0);
        chk("ar pkt_cnt 1", 32'(pkt_cnt), 1);
        chk("ar no drop", 32'(drops - d0), 0);
        read_seq("ar data", 'hE1, 1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
